// File: rtl/ahb_apb_pkg.sv
// Shared types and address map for the AHB-to-APB bridge.
// Used by the AHB slave interface, its decoder and the APB controller.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_REQ,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [31:0] P0_BASE  = 32'h8000_0000;
  localparam logic [31:0] P0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] P1_BASE  = 32'h8400_0000;
  localparam logic [31:0] P1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] P2_BASE  = 32'h8800_0000;
  localparam logic [31:0] P2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_P0   = 3'b001;
  localparam logic [2:0] SEL_P1   = 3'b010;
  localparam logic [2:0] SEL_P2   = 3'b100;

  function automatic logic in_rng(
    input logic [31:0] a,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/ahb_slave_if_if.sv
// Bus bundle between the AHB master, the slave interface
// and the APB controller request port.
interface ahb_slv_bus;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        apb_done;
  logic [31:0] apb_rdata;
  logic        apb_err;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_sel;

  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata,
    input  apb_done, apb_rdata, apb_err,
    output hreadyout, hresp, hrdata,
    output req_valid, req_write, req_addr,
    output req_wdata, req_sel
  );

  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata,
    output apb_done, apb_rdata, apb_err,
    input  hreadyout, hresp, hrdata,
    input  req_valid, req_write, req_addr,
    input  req_wdata, req_sel
  );
endinterface

// File: rtl/ahb_addr_decode.sv
// Combinational APB peripheral select decode.
// hit is low for any address outside the three windows.
module ahb_addr_decode
  import ahb_apb_pkg::*;
(
  input  logic [31:0] haddr,
  output logic [2:0]  sel,
  output logic        hit
);

  always_comb begin
    sel = SEL_NONE;
    unique case (1'b1)
      in_rng(haddr, P0_BASE, P0_LIMIT): sel = SEL_P0;
      in_rng(haddr, P1_BASE, P1_LIMIT): sel = SEL_P1;
      in_rng(haddr, P2_BASE, P2_LIMIT): sel = SEL_P2;
      default:                          sel = SEL_NONE;
    endcase
  end

  assign hit = |sel;

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave side of the AHB-to-APB bridge.
// Build with AHB_SLV_TIMEOUT_EN to abort stuck APB requests.
module ahb_slave_if
  import ahb_apb_pkg::*;
`ifdef AHB_SLV_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
  input logic       hclk,
  input logic       hreset,
  ahb_slv_bus.slave bus
);

  state_t      state, state_n;
  logic        rdy, rdy_n;
  logic [1:0]  resp, resp_n;
  logic [31:0] rdata, rdata_n;
  logic        valid, valid_n;
  logic        wr, wr_n;
  logic [31:0] addr, addr_n;
  logic [31:0] wdata, wdata_n;
  logic [2:0]  sel, sel_n;
  logic [2:0]  dec_sel;
  logic        dec_hit;
  logic        xfer;

`ifdef AHB_SLV_TIMEOUT_EN
  localparam logic [7:0] TO_LAST =
    8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt, cnt_n;
`endif

  ahb_addr_decode u_dec (
    .haddr (bus.haddr),
    .sel   (dec_sel),
    .hit   (dec_hit)
  );

  assign xfer = bus.hreadyin & bus.htrans[1];

  always_comb begin
    state_n = state;
    rdy_n   = rdy;
    resp_n  = resp;
    rdata_n = rdata;
    valid_n = valid;
    wr_n    = wr;
    addr_n  = addr;
    wdata_n = wdata;
    sel_n   = sel;
`ifdef AHB_SLV_TIMEOUT_EN
    cnt_n   = '0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (xfer && dec_hit) begin
          addr_n = bus.haddr;
          sel_n  = dec_sel;
          wr_n   = bus.hwrite;
          rdy_n  = 1'b0;
          if (bus.hwrite) begin
            state_n = ST_WDATA;
          end else begin
            valid_n = 1'b1;
            state_n = ST_REQ;
          end
        end else if (xfer) begin
          rdy_n   = 1'b0;
          resp_n  = HRESP_ERROR;
          state_n = ST_ERR1;
        end
      end
      ST_WDATA: begin
        wdata_n = bus.hwdata;
        valid_n = 1'b1;
        state_n = ST_REQ;
      end
      ST_REQ: begin
        if (bus.apb_done) begin
          valid_n = 1'b0;
          if (!wr) rdata_n = bus.apb_rdata;
          if (bus.apb_err) begin
            resp_n  = HRESP_ERROR;
            state_n = ST_ERR1;
          end else begin
            rdy_n   = 1'b1;
            resp_n  = HRESP_OKAY;
            state_n = ST_IDLE;
          end
        end
`ifdef AHB_SLV_TIMEOUT_EN
        else if (cnt == TO_LAST) begin
          valid_n = 1'b0;
          resp_n  = HRESP_ERROR;
          state_n = ST_ERR1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
`endif
      end
      ST_ERR1: begin
        rdy_n   = 1'b1;
        state_n = ST_ERR2;
      end
      ST_ERR2: begin
        // the master cancels whatever it presents here
        resp_n  = HRESP_OKAY;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state <= ST_IDLE;
      rdy   <= 1'b1;
      resp  <= HRESP_OKAY;
      rdata <= '0;
      valid <= 1'b0;
      wr    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      sel   <= SEL_NONE;
`ifdef AHB_SLV_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_n;
      rdy   <= rdy_n;
      resp  <= resp_n;
      rdata <= rdata_n;
      valid <= valid_n;
      wr    <= wr_n;
      addr  <= addr_n;
      wdata <= wdata_n;
      sel   <= sel_n;
`ifdef AHB_SLV_TIMEOUT_EN
      cnt   <= cnt_n;
`endif
    end
  end

  assign bus.hreadyout = rdy;
  assign bus.hresp     = resp;
  assign bus.hrdata    = rdata;
  assign bus.req_valid = valid;
  assign bus.req_write = wr;
  assign bus.req_addr  = addr;
  assign bus.req_wdata = wdata;
  assign bus.req_sel   = sel;

endmodule
